// File: rtl/uart_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_pkg
// Description : Shared constants and FSM encoding for the UART register
//               bridge: command opcodes, response codes and bridge states.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_bridge_pkg;

    // Command opcodes (first byte of a frame)
    localparam logic [7:0] OP_WR   = 8'h57;   // 'W' addr data
    localparam logic [7:0] OP_RD   = 8'h52;   // 'R' addr

    // Response bytes
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    // Bridge FSM states
    typedef enum logic [2:0] {
        ST_GET  = 3'd0,   // waiting for an RX byte
        ST_RS1  = 3'd1,   // RX pop in flight
        ST_RS2  = 3'd2,   // RX byte valid, parse it
        ST_EXEC = 3'd3,   // register bus strobe cycle
        ST_RDW  = 3'd4,   // read data returning
        ST_TX   = 3'd5,   // waiting for TX FIFO space
        ST_TG   = 3'd6    // TX toggle gap
    } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_bridge_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_bridge_timer
// Description : Inter-byte timeout counter. Counts enabled cycles and emits
//               a one-cycle expiry pulse on the TIMEOUT_CYCLES-th one.
// Ports       : clk       - clock
//               rst_n     - synchronous active-low reset
//               clr_i     - clear the count
//               en_i      - count this cycle
//               expire_o  - one-cycle expiry pulse (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bridge_timer #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_reg_bridge
// Description : Host command responder behind the uart block. Pops RX bytes
//               via the read toggle, parses 'W' addr data / 'R' addr frames,
//               drives a single-master register bus (one-cycle read latency)
//               and returns ACK / read data / NAK via the TX toggle.
// Ports       : clk, rst_n          - clock, synchronous active-low reset
//               uart_rx_ready       - uart RX FIFO non-empty
//               uart_rx_byte        - RX byte after a read toggle
//               uart_rx_read        - read toggle (each change pops a byte)
//               uart_tx_fifo_full   - uart TX FIFO full
//               uart_tx_start       - write toggle (each change pushes)
//               uart_tx_data_in     - response byte
//               reg_addr/reg_wdata  - register bus address / write data
//               reg_we/reg_re       - one-cycle write / read strobes
//               reg_rdata           - read data, valid cycle after reg_re
//               busy                - FSM not waiting for a byte
//               frame_err           - pulse on bad opcode or timeout
// Revision    : 1.0 - initial release
// ============================================================================
module uart_reg_bridge
    import uart_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_ready,
    input  logic [7:0] uart_rx_byte,
    output logic       uart_rx_read,
    input  logic       uart_tx_fifo_full,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_data_in,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       frame_err
);

    state_e     state_q,     state_d;
    logic [1:0] idx_q,       idx_d;
    logic       op_rd_q,     op_rd_d;
    logic [7:0] addr_q,      addr_d;
    logic       rx_read_q,   rx_read_d;
    logic       tx_start_q,  tx_start_d;
    logic [7:0] tx_data_q,   tx_data_d;
    logic [7:0] reg_addr_q,  reg_addr_d;
    logic [7:0] reg_wdata_q, reg_wdata_d;
    logic       reg_we_q,    reg_we_d;
    logic       reg_re_q,    reg_re_d;
    logic       busy_q,      busy_d;
    logic       ferr_q,      ferr_d;

    logic       w_tmr_en;
    logic       w_tmr_expire;

    // The timer only runs while a frame is partially received and no byte is
    // waiting; a waiting byte is popped this cycle, which restarts the count.
    assign w_tmr_en = (state_q == ST_GET) && (idx_q != 2'd0) && !uart_rx_ready;

    uart_bridge_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!w_tmr_en),
        .en_i     (w_tmr_en),
        .expire_o (w_tmr_expire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        op_rd_d     = op_rd_q;
        addr_d      = addr_q;
        rx_read_d   = rx_read_q;
        tx_start_d  = tx_start_q;
        tx_data_d   = tx_data_q;
        reg_addr_d  = reg_addr_q;
        reg_wdata_d = reg_wdata_q;
        reg_we_d    = 1'b0;
        reg_re_d    = 1'b0;
        ferr_d      = 1'b0;

        case (state_q)
            ST_GET: begin
                if (w_tmr_expire) begin
                    idx_d  = 2'd0;
                    ferr_d = 1'b1;
                end else if (uart_rx_ready) begin
                    rx_read_d = ~rx_read_q;
                    state_d   = ST_RS1;
                end
            end
            ST_RS1: begin
                state_d = ST_RS2;
            end
            ST_RS2: begin
                case (idx_q)
                    2'd0: begin
                        if ((uart_rx_byte == OP_WR) || (uart_rx_byte == OP_RD)) begin
                            op_rd_d = (uart_rx_byte == OP_RD);
                            idx_d   = 2'd1;
                            state_d = ST_GET;
                        end else begin
                            tx_data_d = RSP_NAK;
                            ferr_d    = 1'b1;
                            idx_d     = 2'd0;
                            state_d   = ST_TX;
                        end
                    end
                    2'd1: begin
                        addr_d = uart_rx_byte;
                        if (op_rd_q) begin
                            // Strobe is registered so it lands in the EXEC cycle
                            reg_addr_d = uart_rx_byte;
                            reg_re_d   = 1'b1;
                            idx_d      = 2'd2;
                            state_d    = ST_EXEC;
                        end else begin
                            idx_d   = 2'd2;
                            state_d = ST_GET;
                        end
                    end
                    default: begin
                        reg_addr_d  = addr_q;
                        reg_wdata_d = uart_rx_byte;
                        reg_we_d    = 1'b1;
                        state_d     = ST_EXEC;
                    end
                endcase
            end
            ST_EXEC: begin
                if (op_rd_q) begin
                    state_d = ST_RDW;
                end else begin
                    tx_data_d = RSP_ACK;
                    state_d   = ST_TX;
                end
            end
            ST_RDW: begin
                tx_data_d = reg_rdata;
                state_d   = ST_TX;
            end
            ST_TX: begin
                // uart ignores toggles seen while full, so never issue one then
                if (!uart_tx_fifo_full) begin
                    tx_start_d = ~tx_start_q;
                    state_d    = ST_TG;
                end
            end
            ST_TG: begin
                idx_d   = 2'd0;
                state_d = ST_GET;
            end
            default: begin
                idx_d   = 2'd0;
                state_d = ST_GET;
            end
        endcase

        busy_d = (state_d != ST_GET);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_GET;
            idx_q       <= 2'd0;
            op_rd_q     <= 1'b0;
            addr_q      <= 8'h00;
            rx_read_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            reg_addr_q  <= 8'h00;
            reg_wdata_q <= 8'h00;
            reg_we_q    <= 1'b0;
            reg_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_rd_q     <= op_rd_d;
            addr_q      <= addr_d;
            rx_read_q   <= rx_read_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            reg_we_q    <= reg_we_d;
            reg_re_q    <= reg_re_d;
            busy_q      <= busy_d;
            ferr_q      <= ferr_d;
        end
    end

    assign uart_rx_read    = rx_read_q;
    assign uart_tx_start   = tx_start_q;
    assign uart_tx_data_in = tx_data_q;
    assign reg_addr        = reg_addr_q;
    assign reg_wdata       = reg_wdata_q;
    assign reg_we          = reg_we_q;
    assign reg_re          = reg_re_q;
    assign busy            = busy_q;
    assign frame_err       = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_reg_bridge
// Description : Self-checking bench for uart_reg_bridge. Contains a uart
//               toggle-handshake model, a register file, a frame-level
//               reference model and a per-cycle compare process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_reg_bridge;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_ready = 1'b0;
    logic [7:0] uart_rx_byte = 8'h00;
    logic       uart_rx_read;
    logic       uart_tx_fifo_full = 1'b0;
    logic       uart_tx_start;
    logic [7:0] uart_tx_data_in;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;
    logic       frame_err;

    always #5 clk = ~clk;

    uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .uart_rx_ready     (uart_rx_ready),
        .uart_rx_byte      (uart_rx_byte),
        .uart_rx_read      (uart_rx_read),
        .uart_tx_fifo_full (uart_tx_fifo_full),
        .uart_tx_start     (uart_tx_start),
        .uart_tx_data_in   (uart_tx_data_in),
        .reg_addr          (reg_addr),
        .reg_wdata         (reg_wdata),
        .reg_we            (reg_we),
        .reg_re            (reg_re),
        .reg_rdata         (reg_rdata),
        .busy              (busy),
        .frame_err         (frame_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [31:0] got);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected no such event", nm, got);
    endtask

    // ------------------------------------------------------------------
    // Environment: uart toggle model and register file
    // ------------------------------------------------------------------
    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    logic [7:0] regs[256];
    logic       u_prev_rd = 1'b0;
    logic       u_prev_tx = 1'b0;
    int         pop_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            rxq.delete();
            u_prev_rd     <= 1'b0;
            u_prev_tx     <= 1'b0;
            uart_rx_byte  <= 8'h00;
            uart_rx_ready <= 1'b0;
        end else begin
            u_prev_rd <= uart_rx_read;
            if ((uart_rx_read != u_prev_rd) && (rxq.size() > 0)) begin
                uart_rx_byte <= rxq.pop_front();
                pop_cnt      <= pop_cnt + 1;
            end
            uart_rx_ready <= (rxq.size() != 0);
            u_prev_tx <= uart_tx_start;
            if ((uart_tx_start != u_prev_tx) && !uart_tx_fifo_full)
                tx_log.push_back(uart_tx_data_in);
        end
    end

    always @(posedge clk) begin
        if (reg_we) regs[reg_addr] <= reg_wdata;
        reg_rdata <= reg_re ? regs[reg_addr] : 8'h00;
    end

    // ------------------------------------------------------------------
    // Frame-level reference model
    // ------------------------------------------------------------------
    logic [7:0]  m_regs[256];
    int          m_idx = 0;
    logic [7:0]  m_op = 8'h00;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rd[$];
    logic [15:0] exp_wr[$];
    int          exp_ferr = 0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            regs[i]   = 8'(i) ^ 8'h5A;
            m_regs[i] = 8'(i) ^ 8'h5A;
        end
    end

    task automatic model_feed(input logic [7:0] b);
        if (m_idx == 0) begin
            if (b == 8'h57 || b == 8'h52) begin
                m_op  = b;
                m_idx = 1;
            end else begin
                exp_tx.push_back(8'h15);
                exp_ferr++;
            end
        end else if (m_idx == 1) begin
            m_addr = b;
            if (m_op == 8'h52) begin
                exp_rd.push_back(b);
                exp_tx.push_back(m_regs[b]);
                m_idx = 0;
            end else begin
                m_idx = 2;
            end
        end else begin
            exp_wr.push_back({m_addr, b});
            m_regs[m_addr] = b;
            exp_tx.push_back(8'h06);
            m_idx = 0;
        end
    endtask

    task automatic model_timeout();
        m_idx = 0;
        exp_ferr++;
    endtask

    task automatic model_reset();
        m_idx = 0;
        exp_tx.delete();
        exp_rd.delete();
        exp_wr.delete();
    endtask

    // ------------------------------------------------------------------
    // Compare process (samples at negedge)
    // ------------------------------------------------------------------
    int   cyc = 0, last_rx_cyc = 0, last_fe_cyc = 0, tx_lat = 0;
    int   tx_toggles = 0, obs_ferr = 0;
    logic p_rd = 1'b0, p_tx = 1'b0, p_we = 1'b0, p_re = 1'b0, p_fe = 1'b0;
    logic p_busy = 1'b0, p_full = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_n) begin
                if (uart_rx_read !== p_rd) begin
                    chk("rx_pop_while_busy", 32'(p_busy), 0);
                    last_rx_cyc = cyc;
                end
                if (uart_tx_start !== p_tx) begin
                    chk("tx_toggle_while_full", 32'(p_full), 0);
                    tx_lat = cyc - last_rx_cyc;
                    tx_toggles++;
                    if (exp_tx.size() == 0) flag("tx_unexpected", 32'(uart_tx_data_in));
                    else chk("tx_data", 32'(uart_tx_data_in), 32'(exp_tx.pop_front()));
                end
                if (reg_we) begin
                    chk("we_one_cycle", 32'(p_we), 0);
                    chk("we_re_exclusive", 32'(reg_re), 0);
                    if (exp_wr.size() == 0) flag("we_unexpected", {16'h0, reg_addr, reg_wdata});
                    else chk("we_addr_data", {16'h0, reg_addr, reg_wdata}, 32'(exp_wr.pop_front()));
                end
                if (reg_re) begin
                    chk("re_one_cycle", 32'(p_re), 0);
                    if (exp_rd.size() == 0) flag("re_unexpected", 32'(reg_addr));
                    else chk("re_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
                end
                if (frame_err) begin
                    chk("ferr_one_cycle", 32'(p_fe), 0);
                    obs_ferr++;
                    last_fe_cyc = cyc;
                end
            end
            p_rd   = uart_rx_read;
            p_tx   = uart_tx_start;
            p_we   = reg_we;
            p_re   = reg_re;
            p_fe   = frame_err;
            p_busy = busy;
            p_full = uart_tx_fifo_full;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 time unit after the active edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        model_feed(b);
        rxq.push_back(b);
    endtask

    task automatic wait_quiet(input int bound);
        int q = 0;
        int n = 0;
        while (q < 4 && n < bound) begin
            tick();
            n++;
            if (rxq.size() == 0 && exp_tx.size() == 0 && !busy && !uart_rx_ready) q++;
            else q = 0;
        end
        if (q < 4) flag("quiet_timeout", 32'(n));
    endtask

    function automatic logic [7:0] tx_back(input int k);
        if (tx_log.size() > k) return tx_log[tx_log.size() - 1 - k];
        return 8'hxx;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rx_read"},  32'(uart_rx_read), 0);
        chk({tag, "_tx_start"}, 32'(uart_tx_start), 0);
        chk({tag, "_tx_data"},  32'(uart_tx_data_in), 0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 0);
        chk({tag, "_reg_wdata"},32'(reg_wdata), 0);
        chk({tag, "_reg_we"},   32'(reg_we), 0);
        chk({tag, "_reg_re"},   32'(reg_re), 0);
        chk({tag, "_busy"},     32'(busy), 0);
        chk({tag, "_frame_err"},32'(frame_err), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit expected finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int base_tog, base_fe, base_pop, n;

        rst_n = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Write 57 10 A5 -> ACK, 4 cycles pop-to-toggle
        base_tog = tx_toggles;
        send(8'h57); send(8'h10); send(8'hA5);
        wait_quiet(200);
        chk("wr_ack", 32'(tx_back(0)), 32'h06);
        chk("wr_toggles", 32'(tx_toggles - base_tog), 1);
        chk("wr_latency", 32'(tx_lat), 4);
        chk("wr_regfile", 32'(regs[8'h10]), 32'hA5);

        // Read 52 10 -> A5, 5 cycles pop-to-toggle
        send(8'h52); send(8'h10);
        wait_quiet(200);
        chk("rd_data", 32'(tx_back(0)), 32'hA5);
        chk("rd_latency", 32'(tx_lat), 5);

        // Bad opcode then a normal read of 0x20 (0x20^0x5A = 0x7A)
        base_fe = obs_ferr;
        send(8'h41); send(8'h52); send(8'h20);
        wait_quiet(300);
        chk("nak_byte", 32'(tx_back(1)), 32'h15);
        chk("nak_then_read", 32'(tx_back(0)), 32'h7A);
        chk("nak_ferr", 32'(obs_ferr - base_fe), 1);

        // Partial write frame times out
        base_fe  = obs_ferr;
        base_tog = tx_toggles;
        send(8'h57); send(8'h10);
        model_timeout();
        n = 0;
        while (obs_ferr == base_fe && n < 4 * TO + 20) begin
            tick();
            n++;
        end
        chk("to_ferr", 32'(obs_ferr - base_fe), 1);
        chk("to_latency", 32'(last_fe_cyc - last_rx_cyc), 32'(TO + 2));
        chk("to_no_tx", 32'(tx_toggles - base_tog), 0);
        send(8'h52); send(8'h10);
        wait_quiet(200);
        chk("to_next_read", 32'(tx_back(0)), 32'hA5);

        // TX FIFO full during a read response
        uart_tx_fifo_full = 1'b1;
        base_tog = tx_toggles;
        send(8'h52); send(8'h20);
        repeat (50) tick();
        chk("full_hold", 32'(tx_toggles - base_tog), 0);
        chk("full_busy", 32'(busy), 1);
        uart_tx_fifo_full = 1'b0;
        wait_quiet(200);
        chk("full_one_toggle", 32'(tx_toggles - base_tog), 1);
        chk("full_data", 32'(tx_back(0)), 32'h7A);

        // Back-to-back frames, reset after the second opcode
        base_pop = pop_cnt;
        send(8'h57); send(8'h01); send(8'h11); send(8'h52);
        rxq.push_back(8'h01);
        n = 0;
        while (pop_cnt < base_pop + 4 && n < 300) begin
            tick();
            n++;
        end
        chk("rst_pops", 32'(pop_cnt - base_pop), 4);
        chk("rst_wr_ack", 32'(tx_back(0)), 32'h06);
        rst_n = 1'b0;
        model_reset();
        repeat (2) tick();
        chk_all_zero("midrst");
        rst_n = 1'b1;
        tick();
        send(8'h52); send(8'h01);
        wait_quiet(200);
        chk("rst_read_back", 32'(tx_back(0)), 32'h11);

        chk("end_exp_tx", 32'(exp_tx.size()), 0);
        chk("end_exp_wr", 32'(exp_wr.size()), 0);
        chk("end_exp_rd", 32'(exp_rd.size()), 0);
        chk("end_ferr_count", 32'(obs_ferr), 32'(exp_ferr));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
